// File: rtl/cyclic_decoder.sv
// cyclic_decoder: serial decoder for the systematic (7,4) cyclic Hamming code.
// Received bits arrive high-order first (c6..c0). The syndrome is built with
// an LFSR while receiving. A Meggitt pass then rotates the buffer once and
// flips the single bit whose syndrome pattern lines up with SYND_MATCH.
// Optional feature macro: CYCDEC_STATUS_EN adds clr_count/err_count, a
// saturating count of words delivered with a correction applied.
module cyclic_decoder #(
   parameter int N = 7,
   parameter int K = 4,
   parameter logic [N-K:0]   GPOLY      = 4'b1011,
   parameter logic [N-K-1:0] SYND_MATCH = 3'b101
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic           in_bit,
   output logic           in_ready,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [K-1:0]   msg,
   output logic [N-K-1:0] syndrome,
   output logic           corrected
`ifdef CYCDEC_STATUS_EN
   ,
   input  logic           clr_count,
   output logic [7:0]     err_count
`endif
);

   localparam int R  = N - K;
   localparam int CW = $clog2(N);

   // x^e mod g(x), used to confirm SYND_MATCH agrees with GPOLY.
   function automatic logic [R-1:0] xpow_mod_g(input int e);
      logic [R-1:0] s;
      s = R'(1);
      for (int i = 0; i < e; i++) begin
         s = {s[R-2:0], 1'b0} ^ (s[R-1] ? GPOLY[R-1:0] : '0);
      end
      return s;
   endfunction

   generate
      if (xpow_mod_g(N - 1) != SYND_MATCH || GPOLY[R] != 1'b1 || N != (1 << R) - 1) begin : g_param_check
         $fatal(1, "cyclic_decoder: SYND_MATCH, GPOLY and N are inconsistent");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_RECV = 2'd0,
      ST_CORR = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    cw_reg, cw_next;
   logic [R-1:0]    s_reg, s_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [K-1:0]    msg_reg, msg_next;
   logic [R-1:0]    synd_reg, synd_next;
   logic            corr_reg, corr_next;
   logic            valid_reg, valid_next;

   logic            fb_in;
   logic [R-1:0]    lfsr_next;
   logic            hit;

   // Receive feeds the incoming bit into the LFSR; the correction pass feeds zero.
   assign fb_in = (state_reg == ST_RECV) & in_bit;
   assign hit   = (s_reg == SYND_MATCH);

   // Syndrome LFSR: multiply by x, shift in fb_in, reduce by g(x).
   assign lfsr_next[0] = fb_in ^ (s_reg[R-1] & GPOLY[0]);
   generate
      for (genvar gi = 1; gi < R; gi++) begin : g_lfsr
         assign lfsr_next[gi] = s_reg[gi-1] ^ (s_reg[R-1] & GPOLY[gi]);
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_RECV;
      else     state_reg <= state_next;
   end

   // Next-state, datapath next values and handshake outputs.
   always_comb begin
      state_next = state_reg;
      cw_next    = cw_reg;
      s_next     = s_reg;
      count_next = count_reg;
      msg_next   = msg_reg;
      synd_next  = synd_reg;
      corr_next  = corr_reg;
      valid_next = valid_reg;
      in_ready   = 1'b0;
      case (state_reg)
         ST_RECV: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cw_next = {cw_reg[N-2:0], in_bit};
               s_next  = lfsr_next;
               if (count_reg == CW'(N - 1)) begin
                  count_next = '0;
                  synd_next  = lfsr_next;
                  state_next = ST_CORR;
               end else begin
                  count_next = count_reg + 1'b1;
               end
            end
         end
         ST_CORR: begin
            // Rotate the buffer, flipping the outgoing bit when the syndrome
            // has walked round to the pattern of an error in the top position.
            cw_next = {cw_reg[N-2:0], cw_reg[N-1] ^ hit};
            if (hit) begin
               corr_next = 1'b1;
               s_next    = '0;
            end else begin
               s_next = lfsr_next;
            end
            if (count_reg == CW'(N - 1)) begin
               count_next = '0;
               msg_next   = cw_next[N-1 -: K];
               valid_next = 1'b1;
               state_next = ST_OUT;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               valid_next = 1'b0;
               corr_next  = 1'b0;
               s_next     = '0;
               state_next = ST_RECV;
            end
         end
         default: begin
            state_next = ST_RECV;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_reg    <= '0;
         s_reg     <= '0;
         count_reg <= '0;
         msg_reg   <= '0;
         synd_reg  <= '0;
         corr_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         cw_reg    <= cw_next;
         s_reg     <= s_next;
         count_reg <= count_next;
         msg_reg   <= msg_next;
         synd_reg  <= synd_next;
         corr_reg  <= corr_next;
         valid_reg <= valid_next;
      end
   end

   assign out_valid = valid_reg;
   assign msg       = msg_reg;
   assign syndrome  = synd_reg;
   assign corrected = corr_reg;

`ifdef CYCDEC_STATUS_EN
   logic [7:0] err_cnt_reg;

   // Saturating count of delivered words that needed a correction.
   always_ff @(posedge clk) begin
      if (rst || clr_count) begin
         err_cnt_reg <= '0;
      end else if (valid_reg && out_ready && corr_reg && err_cnt_reg != 8'hFF) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign err_count = err_cnt_reg;
`endif

endmodule
